// File: rtl/ctrl_pipe.sv
// Control-signal decode and DEPTH-stage control pipeline with load-use hazard
// detection, flush/stall handling and a saturating illegal-opcode counter.
module ctrl_pipe #(
    parameter int DEPTH     = 3,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6:0]           opcode,
    input  logic [4:0]           rd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 ex_valid,
    output logic [9:0]           ex_ctrl,
    output logic [4:0]           ex_rd,
    output logic                 wb_valid,
    output logic [9:0]           wb_ctrl,
    output logic [4:0]           wb_rd,
    output logic                 load_use,
    output logic [ILL_CNT_W-1:0] ill_count
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ARI_I  = 7'b0010011;
    localparam logic [6:0] OP_ARI_R  = 7'b0110011;

    // ctrl = {illegal, jump, branch, mem_to_reg, mem_read, mem_write, alu_src, reg_write, alu_op[1:0]}
    localparam logic [9:0] CTRL_ILLEGAL = 10'b10_0000_0000;
    localparam logic [9:0] CTRL_BUBBLE  = 10'b00_0000_0000;
    localparam int         MEM_READ_BIT = 5;

    logic [DEPTH-1:0]       r_valid;
    logic [DEPTH-1:0][9:0]  r_ctrl;
    logic [DEPTH-1:0][4:0]  r_rd;
    logic [ILL_CNT_W-1:0]   r_ill_count;

    logic [9:0] w_dec_ctrl;
    logic       w_uses_rs1;
    logic       w_uses_rs2;
    logic       w_load_use;
    logic       w_in_ready;
    logic       w_accept;
    logic       w_ill_inc;
    logic       w_s1_load;
    logic       w_tail_adv;
    logic       w_s1_valid;
    logic [9:0] w_s1_ctrl;
    logic [4:0] w_s1_rd;

    // Opcode decode into the control bundle and source-register usage flags
    always_comb begin
        w_dec_ctrl = CTRL_ILLEGAL;
        w_uses_rs1 = 1'b0;
        w_uses_rs2 = 1'b0;
        case (opcode)
            OP_LUI:    w_dec_ctrl = 10'b00_0000_1100;
            OP_AUIPC:  w_dec_ctrl = 10'b00_0000_1100;
            OP_JAL:    w_dec_ctrl = 10'b01_0000_0100;
            OP_JALR: begin
                w_dec_ctrl = 10'b01_0000_1100;
                w_uses_rs1 = 1'b1;
            end
            OP_BRANCH: begin
                w_dec_ctrl = 10'b00_1000_0001;
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
            end
            OP_LOAD: begin
                w_dec_ctrl = 10'b00_0110_1100;
                w_uses_rs1 = 1'b1;
            end
            OP_STORE: begin
                w_dec_ctrl = 10'b00_0001_1000;
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
            end
            OP_ARI_I: begin
                w_dec_ctrl = 10'b00_0000_1110;
                w_uses_rs1 = 1'b1;
            end
            OP_ARI_R: begin
                w_dec_ctrl = 10'b00_0000_0110;
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
            end
            default: begin
                w_dec_ctrl = CTRL_ILLEGAL;
                w_uses_rs1 = 1'b0;
                w_uses_rs2 = 1'b0;
            end
        endcase
    end

    // Hazard detection, handshake and stage-1 next-value selection
    always_comb begin
        w_load_use = in_valid & r_valid[0] & r_ctrl[0][MEM_READ_BIT] & (r_rd[0] != 5'd0) &
                     ((w_uses_rs1 & (rs1 == r_rd[0])) | (w_uses_rs2 & (rs2 == r_rd[0])));
        w_in_ready = flush | (~stall & ~w_load_use);
        w_accept   = in_valid & w_in_ready & ~flush;
        w_ill_inc  = w_accept & w_dec_ctrl[9] & (r_ill_count != {ILL_CNT_W{1'b1}});
        // Flush overrides stall for stage 1 only; the tail still honours stall.
        w_s1_load  = flush | ~stall;
        w_tail_adv = ~stall;
        if (flush || w_load_use || !in_valid) begin
            w_s1_valid = 1'b0;
            w_s1_ctrl  = CTRL_BUBBLE;
            w_s1_rd    = 5'd0;
        end else begin
            w_s1_valid = 1'b1;
            w_s1_ctrl  = w_dec_ctrl;
            w_s1_rd    = rd;
        end
    end

    // Pipeline stage registers and illegal-opcode counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= '0;
            r_ctrl      <= '0;
            r_rd        <= '0;
            r_ill_count <= '0;
        end else begin
            if (w_s1_load) begin
                r_valid[0] <= w_s1_valid;
                r_ctrl[0]  <= w_s1_ctrl;
                r_rd[0]    <= w_s1_rd;
            end
            if (w_tail_adv) begin
                for (int k = 1; k < DEPTH; k++) begin
                    r_valid[k] <= r_valid[k-1];
                    r_ctrl[k]  <= r_ctrl[k-1];
                    r_rd[k]    <= r_rd[k-1];
                end
            end
            if (w_ill_inc) begin
                r_ill_count <= r_ill_count + {{(ILL_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign load_use  = w_load_use;
    assign ex_valid  = r_valid[0];
    assign ex_ctrl   = r_ctrl[0];
    assign ex_rd     = r_rd[0];
    assign wb_valid  = r_valid[DEPTH-1];
    assign wb_ctrl   = r_ctrl[DEPTH-1];
    assign wb_rd     = r_rd[DEPTH-1];
    assign ill_count = r_ill_count;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: driver pushes model expectations, an
// independent monitor pops and compares; directed scenarios plus random traffic.
module tb_ctrl_pipe;

    localparam int DEPTH     = 3;
    localparam int ILL_CNT_W = 2;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ARI_I  = 7'b0010011;
    localparam logic [6:0] OP_ARI_R  = 7'b0110011;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [6:0]           opcode;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic                 stall;
    logic                 flush;
    logic                 ex_valid;
    logic [9:0]           ex_ctrl;
    logic [4:0]           ex_rd;
    logic                 wb_valid;
    logic [9:0]           wb_ctrl;
    logic [4:0]           wb_rd;
    logic                 load_use;
    logic [ILL_CNT_W-1:0] ill_count;

    always #5 clk = ~clk;

    ctrl_pipe #(.DEPTH(DEPTH), .ILL_CNT_W(ILL_CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_rd(ex_rd),
        .wb_valid(wb_valid), .wb_ctrl(wb_ctrl), .wb_rd(wb_rd),
        .load_use(load_use), .ill_count(ill_count)
    );

    typedef struct packed {
        logic       v;
        logic [9:0] c;
        logic [4:0] r;
    } stage_t;

    typedef struct packed {
        stage_t               ex;
        stage_t               wb;
        logic                 lu;
        logic                 rdy;
        logic [ILL_CNT_W-1:0] ill;
    } exp_t;

    exp_t        exp_q[$];
    stage_t      m_st[DEPTH];
    int unsigned m_ill;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [6:0]  legal_ops[9];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, got, want);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] op);
        return (op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL) || (op == OP_JALR) ||
               (op == OP_BRANCH) || (op == OP_LOAD) || (op == OP_STORE) ||
               (op == OP_ARI_I) || (op == OP_ARI_R);
    endfunction

    // Control bundle assembled field by field from the opcode rules.
    function automatic logic [9:0] ref_ctrl(input logic [6:0] op);
        bit         ld, st, br, jmp, rw, src;
        logic [1:0] aop;
        if (!is_legal(op)) return 10'h200;
        ld  = (op == OP_LOAD);
        st  = (op == OP_STORE);
        br  = (op == OP_BRANCH);
        jmp = (op == OP_JAL) || (op == OP_JALR);
        rw  = !(br || st);
        src = ld || st || (op == OP_ARI_I) || (op == OP_JALR) || (op == OP_LUI) || (op == OP_AUIPC);
        aop = ((op == OP_ARI_I) || (op == OP_ARI_R)) ? 2'b10 : (br ? 2'b01 : 2'b00);
        return {1'b0, jmp, br, ld, ld, st, src, rw, aop};
    endfunction

    function automatic bit ref_load_use();
        bit u1, u2;
        u1 = is_legal(opcode) && !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
        u2 = (opcode == OP_BRANCH) || (opcode == OP_STORE) || (opcode == OP_ARI_R);
        return in_valid && m_st[0].v && m_st[0].c[5] && (m_st[0].r != 5'd0) &&
               ((u1 && (rs1 == m_st[0].r)) || (u2 && (rs2 == m_st[0].r)));
    endfunction

    task automatic shift_tail();
        for (int k = DEPTH - 1; k > 0; k--) m_st[k] = m_st[k-1];
    endtask

    task automatic model_step();
        bit lu;
        lu = ref_load_use();
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) m_st[k] = '0;
            m_ill = 0;
        end else if (flush) begin
            if (!stall) shift_tail();
            m_st[0] = '0;
        end else if (stall) begin
            m_ill = m_ill;
        end else if (lu) begin
            shift_tail();
            m_st[0] = '0;
        end else begin
            shift_tail();
            if (in_valid) begin
                m_st[0] = {1'b1, ref_ctrl(opcode), rd};
                if (!is_legal(opcode) && m_ill < (2 ** ILL_CNT_W) - 1) m_ill++;
            end else begin
                m_st[0] = '0;
            end
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [6:0] op,
                         input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                         input logic st, input logic fl, input bit push);
        exp_t e;
        @(negedge clk);
        rst = r; in_valid = iv; opcode = op; rd = d; rs1 = a; rs2 = b; stall = st; flush = fl;
        #1;
        if (push) begin
            e.ex  = m_st[0];
            e.wb  = m_st[DEPTH-1];
            e.lu  = ref_load_use();
            e.rdy = fl | (!st & !e.lu);
            e.ill = m_ill[ILL_CNT_W-1:0];
            exp_q.push_back(e);
        end
        model_step();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset(input bit push);
        drive(1'b1, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, push);
    endtask

    task automatic issue(input logic [6:0] op, input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
        drive(1'b0, 1'b1, op, d, a, b, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: pops one expectation per cycle and compares all outputs
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_ex_valid",  ex_valid,  e.ex.v);
                chk("sb_ex_ctrl",   ex_ctrl,   e.ex.c);
                chk("sb_ex_rd",     ex_rd,     e.ex.r);
                chk("sb_wb_valid",  wb_valid,  e.wb.v);
                chk("sb_wb_ctrl",   wb_ctrl,   e.wb.c);
                chk("sb_wb_rd",     wb_rd,     e.wb.r);
                chk("sb_load_use",  load_use,  e.lu);
                chk("sb_in_ready",  in_ready,  e.rdy);
                chk("sb_ill_count", ill_count, e.ill);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       rr, iv, st, fl;
        logic [6:0] op;
        int         sel;
        legal_ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_ARI_I, OP_ARI_R};
        rst = 1'b1; in_valid = 1'b0; opcode = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        stall = 1'b0; flush = 1'b0;
        m_ill = 0;
        for (int k = 0; k < DEPTH; k++) m_st[k] = '0;

        do_reset(1'b0);
        do_reset(1'b0);
        idle();
        chk("rst_ex_valid", ex_valid, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_ill", ill_count, 2'd0);

        // ARI_R then illegal: 1-cycle ex latency, DEPTH-cycle wb latency
        issue(OP_ARI_R, 5'd5, 5'd1, 5'd2);
        issue(7'h00, 5'd3, 5'd0, 5'd0);
        chk("arir_ex_ctrl", ex_ctrl, 10'h006);
        chk("arir_ex_rd", ex_rd, 5'd5);
        idle();
        chk("ill_ex_ctrl", ex_ctrl, 10'h200);
        chk("ill_ex_valid", ex_valid, 1'b1);
        idle();
        chk("arir_wb_ctrl", wb_ctrl, 10'h006);
        chk("arir_wb_rd", wb_rd, 5'd5);
        idle();
        chk("ill_wb_ctrl", wb_ctrl, 10'h200);
        chk("ill_cnt_one", ill_count, 2'd1);

        // Load-use: one bubble, dependent instruction enters next cycle
        issue(OP_LOAD, 5'd7, 5'd1, 5'd2);
        issue(OP_ARI_R, 5'd9, 5'd1, 5'd7);
        chk("lu_hit", load_use, 1'b1);
        chk("lu_ready", in_ready, 1'b0);
        issue(OP_ARI_R, 5'd9, 5'd1, 5'd7);
        chk("lu_bubble_v", ex_valid, 1'b0);
        chk("lu_bubble_c", ex_ctrl, 10'h000);
        chk("lu_clear", load_use, 1'b0);
        idle();
        chk("lu_enter_rd", ex_rd, 5'd9);
        chk("lu_enter_v", ex_valid, 1'b1);

        // No hazard on x0 or for an instruction without source registers
        issue(OP_LOAD, 5'd0, 5'd3, 5'd0);
        issue(OP_ARI_R, 5'd4, 5'd0, 5'd0);
        chk("lu_x0", load_use, 1'b0);
        issue(OP_LOAD, 5'd7, 5'd3, 5'd0);
        issue(OP_LUI, 5'd7, 5'd7, 5'd7);
        chk("lu_lui", load_use, 1'b0);
        chk("lu_lui_rdy", in_ready, 1'b1);
        idle();

        // Stall holds a full pipe; flush under stall empties stage 1 only
        issue(OP_ARI_I, 5'd1, 5'd0, 5'd0);
        issue(OP_ARI_I, 5'd2, 5'd0, 5'd0);
        issue(OP_ARI_I, 5'd3, 5'd0, 5'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, OP_ARI_R, 5'd10, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
            chk("stall_ex_rd", ex_rd, 5'd3);
            chk("stall_wb_rd", wb_rd, 5'd1);
            chk("stall_rdy", in_ready, 1'b0);
        end
        drive(1'b0, 1'b1, OP_ARI_R, 5'd10, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
        chk("flush_rdy", in_ready, 1'b1);
        drive(1'b0, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
        chk("flush_ex_v", ex_valid, 1'b0);
        chk("flush_wb_v", wb_valid, 1'b1);
        chk("flush_wb_rd", wb_rd, 5'd1);
        idle();

        // Saturating illegal counter, and a flushed illegal does not count
        do_reset(1'b1);
        for (int k = 0; k < 5; k++) begin
            issue(OP_BAD, 5'd1, 5'd0, 5'd0);
            if (k > 0) chk("ill_sat", ill_count, (k < 3) ? k : 3);
        end
        idle();
        chk("ill_sat_end", ill_count, 2'd3);
        do_reset(1'b1);
        drive(1'b0, 1'b1, OP_BAD, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        idle();
        chk("ill_flushed", ill_count, 2'd0);

        // Reset with a full pipe discards everything
        issue(OP_BAD, 5'd1, 5'd0, 5'd0);
        issue(OP_ARI_I, 5'd2, 5'd0, 5'd0);
        issue(OP_ARI_I, 5'd3, 5'd0, 5'd0);
        do_reset(1'b1);
        idle();
        chk("mid_rst_ex_v", ex_valid, 1'b0);
        chk("mid_rst_wb_v", wb_valid, 1'b0);
        chk("mid_rst_ill", ill_count, 2'd0);

        // Random traffic against the reference model
        for (int i = 0; i < 2000; i++) begin
            rr  = ($urandom_range(0, 99) < 2);
            iv  = ($urandom_range(0, 99) < 80);
            st  = ($urandom_range(0, 99) < 15);
            fl  = ($urandom_range(0, 99) < 10);
            sel = $urandom_range(0, 11);
            op  = (sel < 9) ? legal_ops[sel] : 7'($urandom_range(0, 127));
            drive(rr, iv, op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), st, fl, 1'b1);
        end
        idle();

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        chk("sb_drain", exp_q.size(), 32'd0);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 Parameter DEPTH, default 3, SHALL set the number of control pipeline stages; legal range 2..8.
REQ-002 Parameter ILL_CNT_W, default 8, SHALL set the width of the illegal-opcode counter.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 in_valid  in  1  decode slot holds an instruction.
REQ-007 in_ready  out  1  instruction accepted this cycle.
REQ-008 opcode  in  7  instruction[6:0].
REQ-009 rd, rs1, rs2  in  5 each  register fields.
REQ-010 stall  in  1  external hold of all stages.
REQ-011 flush  in  1  kill the decode slot and stage 1.
REQ-012 ex_valid, ex_ctrl, ex_rd  out  1/10/5  stage-1 bundle.
REQ-013 wb_valid, wb_ctrl, wb_rd  out  1/10/5  stage-DEPTH bundle.
REQ-014 load_use  out  1  load-use hazard detected this cycle (combinational).
REQ-015 ill_count  out  ILL_CNT_W  saturating count of accepted illegal opcodes.

Function
REQ-016 ctrl[9:0] bit order SHALL be {illegal, jump, branch, mem_to_reg, mem_read, mem_write, alu_src, reg_write, alu_op[1:0]}.
REQ-017 Legal opcodes SHALL be LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, ARI_I 0010011, ARI_R 0110011.
REQ-018 reg_write=1 for legal opcodes except BRANCH and STORE.
REQ-019 alu_src=1 for LOAD, STORE, ARI_I, JALR, LUI, AUIPC.
REQ-020 mem_write=STORE; mem_read=mem_to_reg=LOAD; branch=BRANCH; jump=JAL or JALR.
REQ-021 alu_op: 2'b10 for ARI_I/ARI_R, 2'b01 for BRANCH, 2'b00 for all other legal opcodes.
REQ-022 Illegal opcode SHALL produce ctrl=10'b10_0000_0000 (illegal only), valid still propagated.
REQ-023 uses_rs1 = legal and not LUI/AUIPC/JAL; uses_rs2 = BRANCH, STORE or ARI_R.
REQ-024 load_use = in_valid & ex_valid & ex_ctrl.mem_read & ex_rd!=0 & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
REQ-025 in_ready = !stall & !load_use, or 1 when flush=1.
REQ-026 Priority per edge: rst > flush > stall > load_use > normal advance.
REQ-027 Normal advance: stage1 <= decoded input with valid=in_valid; stage k <= stage k-1 for k=2..DEPTH; latency opcode->ex 1 cycle, ->wb DEPTH cycles.
REQ-028 stall=1, flush=0: all stages hold; input not accepted.
REQ-029 flush=1: stage1 <= bubble (valid=0, ctrl=0, rd=0); input consumed and discarded; stages 2..DEPTH advance if stall=0, else hold.
REQ-030 load_use=1, stall=0, flush=0: stage1 <= bubble, stages 2..DEPTH advance, input held (in_ready=0).
REQ-031 Bubbles SHALL carry ctrl=0 and rd=0 so no write side effects.
REQ-032 ill_count SHALL increment by 1 when an illegal opcode is accepted (in_valid & in_ready & !flush) and saturate at all-ones.

Reset
REQ-033 On rst=1 at an edge: all stage valid=0, ctrl=0, rd=0, ill_count=0; load_use=0 and in_ready=1 in the cycle after (absent stall).
REQ-034 rst mid-operation SHALL discard all in-flight bundles; no partial state survives.

Verification
REQ-035 DEPTH=3: ARI_R rd=5 then 0x00 opcode -> ex_ctrl=10'b00_0000_0110 after 1 cycle, wb_ctrl same after 3; illegal ctrl=10'h200 follows one cycle later.
REQ-036 LOAD rd=7 then ARI_R rs2=7 -> load_use=1, in_ready=0 one cycle, ex_valid=0 bubble, ARI_R enters stage1 next cycle.
REQ-037 LOAD rd=0 then ARI_R rs1=0; and LOAD rd=7 then LUI rd=7 -> load_use=0 both cases.
REQ-038 stall=1 for 4 cycles with full pipe -> ex/wb outputs constant, in_ready=0; flush with stall -> ex_valid=0, wb unchanged.
REQ-039 ILL_CNT_W=2: 5 accepted illegal opcodes -> ill_count 1,2,3,3,3; flushed illegal opcode -> no increment.
REQ-040 rst asserted with 3 valid stages -> next cycle ex_valid=wb_valid=0, ill_count=0.
